ram_program_loader: RTL and testbench

Host-side sequencer that takes ownership of the CPU bus and RAM through the HALT path and writes a program image into RAM. It accepts a word stream over a valid/ready handshake, then returns control to the CPU. It sits between a host or test interface and the CPU top's DATA, ADDRESS, EXT_RAM_EN, EXT_RAM_RW and HALT inputs. It replaces hand-driven HALT/bus sequencing in benches and boards.

---
 rtl/ram_program_loader_pkg.sv | 30 +++
 rtl/ram_program_loader_if.sv | 37 +++
 rtl/ram_program_loader_down_counter.sv | 31 +++
 rtl/ram_program_loader.sv | 162 ++++++++++++++++
 tb/tb_ram_program_loader.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/ram_program_loader_pkg.sv
// Shared types and constants for the RAM program loader: FSM states,
// RAM direction encodings and default bus widths.
package ram_loader_pkg;

    localparam int   ADDR_W_DEF = 16;
    localparam int   DATA_W_DEF = 16;
    localparam int   SETTLE_W   = 4;
    localparam logic RAM_WRITE  = 1'b1;
    localparam logic RAM_READ   = 1'b0;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETTLE    = 3'd1,
        WAIT_DATA = 3'd2,
        WRITE     = 3'd3,
        RELEASE   = 3'd4
    } state_e;

    // Clamp the settle length into the range the 4-bit counter can hold.
    function automatic logic [SETTLE_W-1:0] settle_load_value(input int cycles);
        if (cycles < 1) begin
            return 4'd1;
        end else if (cycles > 15) begin
            return 4'd15;
        end else begin
            return SETTLE_W'(cycles);
        end
    endfunction

endpackage

// File: rtl/ram_program_loader_if.sv
// Host stream, control/status and CPU bus signals of the loader, grouped so
// the host side (master) and the loader (slave) connect through one port.
interface ram_program_loader_if
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              START;
    logic              ABORT;
    logic [ADDR_W-1:0] BASE_ADDR;
    logic [ADDR_W-1:0] WORD_COUNT;
    logic [DATA_W-1:0] IN_DATA;
    logic              IN_VALID;
    logic              IN_READY;
    logic              HALT;
    logic [ADDR_W-1:0] EXT_ADDR;
    logic [DATA_W-1:0] EXT_DATA;
    logic              EXT_RAM_EN;
    logic              EXT_RAM_RW;
    logic              BUSY;
    logic              DONE;
    logic              ABORTED;
    logic [ADDR_W-1:0] WORDS_WRITTEN;

    modport master (
        output START, ABORT, BASE_ADDR, WORD_COUNT, IN_DATA, IN_VALID,
        input  IN_READY, HALT, EXT_ADDR, EXT_DATA, EXT_RAM_EN, EXT_RAM_RW,
               BUSY, DONE, ABORTED, WORDS_WRITTEN
    );

    modport slave (
        input  START, ABORT, BASE_ADDR, WORD_COUNT, IN_DATA, IN_VALID,
        output IN_READY, HALT, EXT_ADDR, EXT_DATA, EXT_RAM_EN, EXT_RAM_RW,
               BUSY, DONE, ABORTED, WORDS_WRITTEN
    );
endinterface

// File: rtl/ram_program_loader_down_counter.sv
// Loadable down-counter with zero/one flags; used for the settle delay and
// for the remaining-word count. Decrement saturates at zero.
module loader_down_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         is_zero,
    output logic         is_one
);
    logic [W-1:0] count_r;

    // Count register: load has priority over decrement.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= '0;
        end else if (load) begin
            count_r <= load_value;
        end else if (dec && (count_r != '0)) begin
            count_r <= count_r - W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign is_zero = (count_r == '0);
    assign is_one  = (count_r == W'(1));
endmodule

// File: rtl/ram_program_loader.sv
// Halts the CPU, streams a program image into RAM over valid/ready, then
// releases the bus and reports completion with a one-cycle DONE pulse.
module ram_program_loader
    import ram_loader_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int SETTLE_CYCLES = 2
) (
    input logic                 CLK,
    input logic                 RST,
    ram_program_loader_if.slave bus
);
    state_e            state_r;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] ext_addr_r;
    logic [ADDR_W-1:0] words_r;
    logic [DATA_W-1:0] ext_data_r;
    logic              halt_r;
    logic              ram_en_r;
    logic              ram_rw_r;
    logic              busy_r;
    logic              done_r;
    logic              aborted_r;

    logic settle_load_s, settle_dec_s, settle_zero_s, settle_one_s;
    logic rem_load_s, rem_dec_s, rem_zero_s, rem_one_s;

    assign settle_load_s = (state_r == IDLE) && bus.START;
    assign rem_load_s    = settle_load_s;
    assign settle_dec_s  = (state_r == SETTLE);
    assign rem_dec_s     = (state_r == WRITE);

    loader_down_counter #(.W(SETTLE_W)) u_settle_cnt (
        .clk        (CLK),
        .rst        (RST),
        .load       (settle_load_s),
        .load_value (settle_load_value(SETTLE_CYCLES)),
        .dec        (settle_dec_s),
        .is_zero    (settle_zero_s),
        .is_one     (settle_one_s)
    );

    loader_down_counter #(.W(ADDR_W)) u_remain_cnt (
        .clk        (CLK),
        .rst        (RST),
        .load       (rem_load_s),
        .load_value (bus.WORD_COUNT),
        .dec        (rem_dec_s),
        .is_zero    (rem_zero_s),
        .is_one     (rem_one_s)
    );

    // Sequencer FSM; every bus-facing output is registered and only changes
    // on the edge that moves the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= IDLE;
            addr_r     <= '0;
            ext_addr_r <= '0;
            ext_data_r <= '0;
            words_r    <= '0;
            halt_r     <= 1'b0;
            ram_en_r   <= 1'b0;
            ram_rw_r   <= RAM_READ;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            aborted_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r    <= 1'b0;
                    aborted_r <= 1'b0;
                    if (bus.START) begin
                        addr_r  <= bus.BASE_ADDR;
                        words_r <= '0;
                        halt_r  <= 1'b1;
                        busy_r  <= 1'b1;
                        state_r <= SETTLE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SETTLE: begin
                    if (bus.ABORT) begin
                        halt_r    <= 1'b0;
                        done_r    <= 1'b1;
                        aborted_r <= 1'b1;
                        state_r   <= RELEASE;
                    end else if (settle_one_s || settle_zero_s) begin
                        if (rem_zero_s) begin
                            halt_r    <= 1'b0;
                            done_r    <= 1'b1;
                            aborted_r <= 1'b0;
                            state_r   <= RELEASE;
                        end else begin
                            state_r <= WAIT_DATA;
                        end
                    end else begin
                        state_r <= SETTLE;
                    end
                end
                WAIT_DATA: begin
                    // ABORT wins over a word offered in the same cycle.
                    if (bus.ABORT) begin
                        halt_r    <= 1'b0;
                        done_r    <= 1'b1;
                        aborted_r <= 1'b1;
                        state_r   <= RELEASE;
                    end else if (bus.IN_VALID) begin
                        ext_data_r <= bus.IN_DATA;
                        ext_addr_r <= addr_r;
                        ram_en_r   <= 1'b1;
                        ram_rw_r   <= RAM_WRITE;
                        state_r    <= WRITE;
                    end else begin
                        state_r <= WAIT_DATA;
                    end
                end
                WRITE: begin
                    ram_en_r <= 1'b0;
                    ram_rw_r <= RAM_READ;
                    addr_r   <= addr_r + ADDR_W'(1);
                    words_r  <= words_r + ADDR_W'(1);
                    if (bus.ABORT || rem_one_s) begin
                        halt_r    <= 1'b0;
                        done_r    <= 1'b1;
                        aborted_r <= bus.ABORT;
                        state_r   <= RELEASE;
                    end else begin
                        state_r <= WAIT_DATA;
                    end
                end
                RELEASE: begin
                    done_r    <= 1'b0;
                    aborted_r <= 1'b0;
                    busy_r    <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    halt_r   <= 1'b0;
                    ram_en_r <= 1'b0;
                    ram_rw_r <= RAM_READ;
                    busy_r   <= 1'b0;
                    done_r   <= 1'b0;
                    state_r  <= IDLE;
                end
            endcase
        end
    end

    assign bus.IN_READY      = (state_r == WAIT_DATA) && !bus.ABORT;
    assign bus.HALT          = halt_r;
    assign bus.EXT_ADDR      = ext_addr_r;
    assign bus.EXT_DATA      = ext_data_r;
    assign bus.EXT_RAM_EN    = ram_en_r;
    assign bus.EXT_RAM_RW    = ram_rw_r;
    assign bus.BUSY          = busy_r;
    assign bus.DONE          = done_r;
    assign bus.ABORTED       = aborted_r;
    assign bus.WORDS_WRITTEN = words_r;
endmodule

// File: tb/tb_ram_program_loader.sv
// Directed self-checking bench for ram_program_loader: each scenario task
// drives a load, records bus activity per cycle and checks it inline.
module tb_ram_program_loader;
    localparam int SETTLE = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ram_program_loader_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    ram_program_loader #(.ADDR_W(16), .DATA_W(16), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Per-load records; cycle k is the k-th falling edge after the START edge.
    int          n_wr, first_halt, done_cnt, done_cyc, bad_wr, busy_low;
    int          halt_gap, ready_abort_viol, valid_rise;
    logic [15:0] wr_addr [8];
    logic [15:0] wr_data [8];
    int          wr_cyc  [8];
    logic        done_ab, done_halt, busy_after;
    logic [15:0] done_words, hold_addr;

    task automatic run_load(input logic [15:0] base, input logic [15:0] count,
                            input logic [15:0] data_base, input int gap_word,
                            input int gap_len, input int abort_after, input int restart_cyc);
        int   accepted = 0;
        int   gap_left = gap_len;
        int   post_done = -1;
        logic abort_issued = 1'b0;
        logic prev_valid;
        logic en_now;
        n_wr = 0; first_halt = -1; done_cnt = 0; done_cyc = -1; bad_wr = 0;
        busy_low = 0; halt_gap = 0; ready_abort_viol = 0; valid_rise = -1;
        done_ab = 1'bx; done_halt = 1'bx; busy_after = 1'bx;
        done_words = 16'hxxxx; hold_addr = 16'hxxxx;
        for (int i = 0; i < 8; i++) begin
            wr_cyc[i] = -1; wr_addr[i] = 16'hxxxx; wr_data[i] = 16'hxxxx;
        end
        @(negedge clk);
        bus.START = 1'b1; bus.BASE_ADDR = base; bus.WORD_COUNT = count;
        bus.ABORT = 1'b0; bus.IN_DATA = data_base; bus.IN_VALID = (count != 16'd0);
        prev_valid = bus.IN_VALID;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            en_now = bus.EXT_RAM_EN;
            if (bus.HALT && first_halt < 0) first_halt = k;
            if (first_halt > 0 && done_cyc < 0 && !bus.HALT && !bus.DONE) halt_gap++;
            if (en_now) begin
                if (n_wr < 8) begin
                    wr_addr[n_wr] = bus.EXT_ADDR; wr_data[n_wr] = bus.EXT_DATA; wr_cyc[n_wr] = k;
                end
                n_wr++;
                if (!bus.EXT_RAM_RW || !bus.HALT) bad_wr++;
            end else if (bus.EXT_RAM_RW) begin
                bad_wr++;
            end
            if (n_wr >= 1 && k == wr_cyc[0] + 1) hold_addr = bus.EXT_ADDR;
            if (done_cyc < 0 && !bus.BUSY) busy_low++;
            if (bus.DONE) begin
                done_cnt++;
                if (done_cyc < 0) begin
                    done_cyc = k; done_ab = bus.ABORTED; done_halt = bus.HALT;
                    done_words = bus.WORDS_WRITTEN; post_done = k;
                end
            end
            if (post_done >= 0 && k == post_done + 2) begin
                busy_after = bus.BUSY;
                break;
            end
            bus.START = (k == restart_cyc);
            if (k == restart_cyc) begin
                bus.BASE_ADDR = base ^ 16'h00C0; bus.WORD_COUNT = count + 16'd7;
            end
            if (abort_after > 0 && n_wr == abort_after && !abort_issued && !en_now) begin
                bus.ABORT = 1'b1; abort_issued = 1'b1;
            end else begin
                bus.ABORT = 1'b0;
            end
            if (accepted == gap_word && gap_left > 0) begin
                bus.IN_VALID = 1'b0; gap_left--;
            end else begin
                bus.IN_VALID = (accepted < int'(count));
            end
            if (bus.IN_VALID && !prev_valid) valid_rise = k;
            prev_valid = bus.IN_VALID;
            bus.IN_DATA = data_base + 16'(accepted);
            #1;
            if (bus.ABORT && bus.IN_READY) ready_abort_viol++;
            if (bus.IN_READY && bus.IN_VALID) accepted++;
        end
        bus.START = 1'b0; bus.ABORT = 1'b0; bus.IN_VALID = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.HALT !== 1'b0) begin failures++; $display("FAIL reset_halt got=%b exp=0", bus.HALT); end
        checks++; if (bus.BUSY !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.BUSY); end
        checks++; if (bus.DONE !== 1'b0 || bus.ABORTED !== 1'b0) begin failures++; $display("FAIL reset_done got=%b%b exp=00", bus.DONE, bus.ABORTED); end
        checks++; if (bus.EXT_RAM_EN !== 1'b0 || bus.EXT_RAM_RW !== 1'b0) begin failures++; $display("FAIL reset_ram got=%b%b exp=00", bus.EXT_RAM_EN, bus.EXT_RAM_RW); end
        checks++; if (bus.EXT_ADDR !== 16'h0000 || bus.EXT_DATA !== 16'h0000) begin failures++; $display("FAIL reset_bus got=%h/%h exp=0000/0000", bus.EXT_ADDR, bus.EXT_DATA); end
        checks++; if (bus.WORDS_WRITTEN !== 16'h0000 || bus.IN_READY !== 1'b0) begin failures++; $display("FAIL reset_misc got=%h/%b exp=0000/0", bus.WORDS_WRITTEN, bus.IN_READY); end
        rst = 1'b0;
    endtask

    task automatic test_basic;
        run_load(16'h0010, 16'd3, 16'hA001, -1, 0, 0, -1);
        checks++; if (first_halt !== 1) begin failures++; $display("FAIL basic_halt_start got=%0d exp=1", first_halt); end
        checks++; if (n_wr !== 3) begin failures++; $display("FAIL basic_nwr got=%0d exp=3", n_wr); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (wr_addr[i] !== 16'(16'h0010 + i)) begin failures++; $display("FAIL basic_addr%0d got=%h exp=%h", i, wr_addr[i], 16'(16'h0010 + i)); end
            checks++; if (wr_data[i] !== 16'(16'hA001 + i)) begin failures++; $display("FAIL basic_data%0d got=%h exp=%h", i, wr_data[i], 16'(16'hA001 + i)); end
            checks++; if (wr_cyc[i] !== 2 + SETTLE + 2 * i) begin failures++; $display("FAIL basic_wcyc%0d got=%0d exp=%0d", i, wr_cyc[i], 2 + SETTLE + 2 * i); end
        end
        checks++; if (hold_addr !== 16'h0010) begin failures++; $display("FAIL basic_addr_hold got=%h exp=0010", hold_addr); end
        checks++; if (bad_wr !== 0 || busy_low !== 0 || halt_gap !== 0) begin failures++; $display("FAIL basic_ctrl got=%0d/%0d/%0d exp=0/0/0", bad_wr, busy_low, halt_gap); end
        checks++; if (done_cnt !== 1 || done_cyc !== 9) begin failures++; $display("FAIL basic_done got=%0d@%0d exp=1@9", done_cnt, done_cyc); end
        checks++; if (done_ab !== 1'b0 || done_halt !== 1'b0) begin failures++; $display("FAIL basic_status got=%b/%b exp=0/0", done_ab, done_halt); end
        checks++; if (done_words !== 16'd3 || bus.WORDS_WRITTEN !== 16'd3) begin failures++; $display("FAIL basic_words got=%0d/%0d exp=3/3", done_words, bus.WORDS_WRITTEN); end
        checks++; if (busy_after !== 1'b0 || bus.HALT !== 1'b0) begin failures++; $display("FAIL basic_idle got=%b/%b exp=0/0", busy_after, bus.HALT); end
    endtask

    task automatic test_back_pressure;
        run_load(16'h0010, 16'd3, 16'hA001, 1, 5, 0, -1);
        checks++; if (n_wr !== 3) begin failures++; $display("FAIL bp_nwr got=%0d exp=3", n_wr); end
        checks++; if (wr_cyc[0] !== 4 || wr_cyc[1] !== 10 || wr_cyc[2] !== 12) begin failures++; $display("FAIL bp_wcyc got=%0d,%0d,%0d exp=4,10,12", wr_cyc[0], wr_cyc[1], wr_cyc[2]); end
        checks++; if (valid_rise !== 9 || wr_cyc[1] !== valid_rise + 1) begin failures++; $display("FAIL bp_rise got=%0d->%0d exp=9->10", valid_rise, wr_cyc[1]); end
        checks++; if (wr_addr[1] !== 16'h0011 || wr_data[1] !== 16'hA002) begin failures++; $display("FAIL bp_word2 got=%h/%h exp=0011/a002", wr_addr[1], wr_data[1]); end
        checks++; if (halt_gap !== 0 || bad_wr !== 0) begin failures++; $display("FAIL bp_halt got=%0d/%0d exp=0/0", halt_gap, bad_wr); end
        checks++; if (done_cyc !== 13 || done_words !== 16'd3 || done_ab !== 1'b0) begin failures++; $display("FAIL bp_done got=%0d/%0d/%b exp=13/3/0", done_cyc, done_words, done_ab); end
    endtask

    task automatic test_zero_and_wrap;
        run_load(16'h0020, 16'd0, 16'h0000, -1, 0, 0, -1);
        checks++; if (n_wr !== 0 || bad_wr !== 0) begin failures++; $display("FAIL zero_nwr got=%0d/%0d exp=0/0", n_wr, bad_wr); end
        checks++; if (first_halt !== 1 || done_cyc !== SETTLE + 1) begin failures++; $display("FAIL zero_timing got=%0d/%0d exp=1/%0d", first_halt, done_cyc, SETTLE + 1); end
        checks++; if (done_words !== 16'd0 || done_ab !== 1'b0 || done_halt !== 1'b0) begin failures++; $display("FAIL zero_status got=%0d/%b/%b exp=0/0/0", done_words, done_ab, done_halt); end
        run_load(16'hFFFF, 16'd2, 16'hB000, -1, 0, 0, -1);
        checks++; if (n_wr !== 2) begin failures++; $display("FAIL wrap_nwr got=%0d exp=2", n_wr); end
        checks++; if (wr_addr[0] !== 16'hFFFF || wr_addr[1] !== 16'h0000) begin failures++; $display("FAIL wrap_addr got=%h,%h exp=ffff,0000", wr_addr[0], wr_addr[1]); end
        checks++; if (wr_data[0] !== 16'hB000 || wr_data[1] !== 16'hB001) begin failures++; $display("FAIL wrap_data got=%h,%h exp=b000,b001", wr_data[0], wr_data[1]); end
        checks++; if (done_cyc !== 7 || done_words !== 16'd2) begin failures++; $display("FAIL wrap_done got=%0d/%0d exp=7/2", done_cyc, done_words); end
    endtask

    task automatic test_abort;
        run_load(16'h0040, 16'd4, 16'hC000, -1, 0, 2, -1);
        checks++; if (n_wr !== 2) begin failures++; $display("FAIL abort_nwr got=%0d exp=2", n_wr); end
        checks++; if (ready_abort_viol !== 0) begin failures++; $display("FAIL abort_ready got=%0d exp=0", ready_abort_viol); end
        checks++; if (done_cnt !== 1 || done_cyc !== 8) begin failures++; $display("FAIL abort_done got=%0d@%0d exp=1@8", done_cnt, done_cyc); end
        checks++; if (done_ab !== 1'b1 || done_halt !== 1'b0 || done_words !== 16'd2) begin failures++; $display("FAIL abort_status got=%b/%b/%0d exp=1/0/2", done_ab, done_halt, done_words); end
        checks++; if (busy_after !== 1'b0) begin failures++; $display("FAIL abort_idle got=%b exp=0", busy_after); end
    endtask

    task automatic test_ignored_start;
        run_load(16'h0050, 16'd3, 16'h1230, -1, 0, 0, 5);
        checks++; if (n_wr !== 3) begin failures++; $display("FAIL istart_nwr got=%0d exp=3", n_wr); end
        checks++; if (wr_addr[0] !== 16'h0050 || wr_addr[1] !== 16'h0051 || wr_addr[2] !== 16'h0052) begin failures++; $display("FAIL istart_addr got=%h,%h,%h exp=0050,0051,0052", wr_addr[0], wr_addr[1], wr_addr[2]); end
        checks++; if (done_cyc !== 9 || done_words !== 16'd3) begin failures++; $display("FAIL istart_done got=%0d/%0d exp=9/3", done_cyc, done_words); end
    endtask

    task automatic test_reset_mid_load;
        int dones = 0;
        @(negedge clk);
        bus.START = 1'b1; bus.BASE_ADDR = 16'h0060; bus.WORD_COUNT = 16'd3;
        bus.IN_VALID = 1'b1; bus.IN_DATA = 16'hD000;
        @(negedge clk);
        bus.START = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.EXT_RAM_EN !== 1'b1 || bus.EXT_ADDR !== 16'h0060) begin failures++; $display("FAIL rmid_first_write got=%b/%h exp=1/0060", bus.EXT_RAM_EN, bus.EXT_ADDR); end
        bus.IN_DATA = 16'hD001;
        @(negedge clk);
        checks++; if (bus.IN_READY !== 1'b1 || bus.HALT !== 1'b1) begin failures++; $display("FAIL rmid_wait got=%b/%b exp=1/1", bus.IN_READY, bus.HALT); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.HALT !== 1'b0 || bus.BUSY !== 1'b0 || bus.DONE !== 1'b0) begin failures++; $display("FAIL rmid_ctrl got=%b/%b/%b exp=0/0/0", bus.HALT, bus.BUSY, bus.DONE); end
        checks++; if (bus.EXT_RAM_EN !== 1'b0 || bus.EXT_ADDR !== 16'h0000 || bus.EXT_DATA !== 16'h0000) begin failures++; $display("FAIL rmid_bus got=%b/%h/%h exp=0/0000/0000", bus.EXT_RAM_EN, bus.EXT_ADDR, bus.EXT_DATA); end
        checks++; if (bus.WORDS_WRITTEN !== 16'd0 || bus.ABORTED !== 1'b0) begin failures++; $display("FAIL rmid_status got=%0d/%b exp=0/0", bus.WORDS_WRITTEN, bus.ABORTED); end
        rst = 1'b0; bus.IN_VALID = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (bus.DONE) dones++;
        end
        checks++; if (dones !== 0 || bus.BUSY !== 1'b0) begin failures++; $display("FAIL rmid_nodone got=%0d/%b exp=0/0", dones, bus.BUSY); end
        run_load(16'h0070, 16'd2, 16'hE000, -1, 0, 0, -1);
        checks++; if (n_wr !== 2 || wr_addr[0] !== 16'h0070 || wr_addr[1] !== 16'h0071) begin failures++; $display("FAIL rmid_reload got=%0d:%h,%h exp=2:0070,0071", n_wr, wr_addr[0], wr_addr[1]); end
        checks++; if (done_cyc !== 7 || done_words !== 16'd2 || done_ab !== 1'b0) begin failures++; $display("FAIL rmid_reload_done got=%0d/%0d/%b exp=7/2/0", done_cyc, done_words, done_ab); end
    endtask

    initial begin
        bus.START = 1'b0; bus.ABORT = 1'b0; bus.BASE_ADDR = 16'h0000;
        bus.WORD_COUNT = 16'h0000; bus.IN_DATA = 16'h0000; bus.IN_VALID = 1'b0;
        test_reset();
        test_basic();
        test_back_pressure();
        test_zero_and_wrap();
        test_abort();
        test_ignored_start();
        test_reset_mid_load();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
